// File: rtl/hybrid_tree_scheduler.sv
// hybrid_tree_scheduler: shares one hybrid_tree max-priority queue between
// NUM_REQ requesters. Round-robin arbitration, single-cycle queue strobes,
// per-operation recovery gap, full/empty legality checks and a response
// carrying the removed root back to the requester.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   req_valid/op/data   per-requester request (op: 00 enq, 01 deq, 10 repl)
//   req_ready           one-hot grant, only while idle
//   rsp_valid/id/data   response pulse, requester index, removed root
//   rsp_err             request rejected, no queue operation performed
//   q_wrt/q_read/q_data queue strobes and write key
//   q_full/q_empty/q_top queue flags and root value
//   busy                controller not idle
module hybrid_tree_scheduler #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ENQ_GAP    = 4,
    parameter int unsigned DEQ_GAP    = 24,
    parameter int unsigned REPL_GAP   = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [2*NUM_REQ-1:0]          req_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic                          q_wrt,
    output logic                          q_read,
    output logic [DATA_WIDTH-1:0]         q_data,
    input  logic                          q_full,
    input  logic                          q_empty,
    input  logic [DATA_WIDTH-1:0]         q_top,
    output logic                          busy
);

    localparam int unsigned ID_W     = $clog2(NUM_REQ);
    localparam int unsigned MAX_GAP1 = (ENQ_GAP > DEQ_GAP) ? ENQ_GAP : DEQ_GAP;
    localparam int unsigned MAX_GAP  = (MAX_GAP1 > REPL_GAP) ? MAX_GAP1 : REPL_GAP;
    localparam int unsigned CNT_W    = (MAX_GAP > 0) ? $clog2(MAX_GAP + 1) : 1;

    localparam logic [1:0] OP_ENQ  = 2'b00;
    localparam logic [1:0] OP_DEQ  = 2'b01;
    localparam logic [1:0] OP_REPL = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t                 state, state_next;
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        win_id;
    logic [1:0]             win_op;
    logic [DATA_WIDTH-1:0]  win_data;
    logic                   found;
    logic                   grant;
    logic                   legal;
    logic [1:0]             lat_op;
    logic [ID_W-1:0]        lat_id;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       gap_sel;

    // Requester index k positions after the round-robin pointer.
    function automatic int unsigned rr_index(input logic [ID_W-1:0] base, input int unsigned k);
        return (32'(base) + k) % NUM_REQ;
    endfunction

    // Round-robin search: first valid requester at or after rr_ptr.
    always_comb begin
        found    = 1'b0;
        win_id   = '0;
        win_op   = '0;
        win_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[rr_index(rr_ptr, k)]) begin
                found    = 1'b1;
                win_id   = ID_W'(rr_index(rr_ptr, k));
                win_op   = req_op[2*rr_index(rr_ptr, k) +: 2];
                win_data = req_data[rr_index(rr_ptr, k)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign grant = found && (state == IDLE) && !RST;

    // Legality against the queue flags seen in the grant cycle.
    always_comb begin
        legal = 1'b0;
        case (win_op)
            OP_ENQ:  legal = !q_full;
            OP_DEQ:  legal = !q_empty;
            OP_REPL: legal = !q_empty;
            default: legal = 1'b0;
        endcase
    end

    // Recovery gap of the operation just issued.
    always_comb begin
        gap_sel = '0;
        case (lat_op)
            OP_ENQ:  gap_sel = CNT_W'(ENQ_GAP);
            OP_DEQ:  gap_sel = CNT_W'(DEQ_GAP);
            OP_REPL: gap_sel = CNT_W'(REPL_GAP);
            default: gap_sel = '0;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and grant decode; req_ready must answer in the grant cycle.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (grant) begin
                    req_ready[win_id] = 1'b1;
                    state_next        = legal ? ISSUE : ERR;
                end
            end
            ISSUE:   state_next = (gap_sel == '0) ? IDLE : WAIT;
            WAIT:    if (cnt <= CNT_W'(1)) state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered datapath: latches, strobes, gap counter and response.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr    <= '0;
            lat_op    <= '0;
            lat_id    <= '0;
            cnt       <= '0;
            q_wrt     <= 1'b0;
            q_read    <= 1'b0;
            q_data    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            q_wrt     <= 1'b0;
            q_read    <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (grant) begin
                        lat_op <= win_op;
                        lat_id <= win_id;
                        q_data <= win_data;
                        rr_ptr <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
                        if (legal) begin
                            q_wrt  <= (win_op == OP_ENQ) || (win_op == OP_REPL);
                            q_read <= (win_op == OP_DEQ) || (win_op == OP_REPL);
                        end
                    end
                end
                ISSUE: begin
                    cnt       <= gap_sel;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_id    <= lat_id;
                    rsp_data  <= (lat_op == OP_ENQ) ? '0 : q_top;
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                end
                ERR: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_id    <= lat_id;
                    rsp_data  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hybrid_tree_scheduler.sv
// Directed bench for hybrid_tree_scheduler with a small max-queue model
// standing in for the hybrid_tree.
module tb_hybrid_tree_scheduler;

    localparam int unsigned N    = 4;
    localparam int unsigned DW   = 16;
    localparam int unsigned QCAP = 8;

    logic              CLK = 1'b0;
    logic              RST;
    logic [N-1:0]      req_valid;
    logic [2*N-1:0]    req_op;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;
    logic              q_wrt;
    logic              q_read;
    logic [DW-1:0]     q_data;
    logic              q_full;
    logic              q_empty;
    logic [DW-1:0]     q_top;
    logic              busy;

    int checks = 0;
    int errors = 0;

    int          qm[$];
    logic        force_full = 1'b0;
    logic        pend = 1'b0;
    logic        pend_w;
    logic        pend_r;
    logic [DW-1:0] pend_d;

    int grants;
    int strobes;
    int g;
    int exp_id[8]   = '{1, 2, 3, 0, 1, 2, 3, 0};
    int exp_data[8] = '{400, 2000, 300, 150, 1000, 2000, 150, 5};
    int rdata[4]    = '{1000, 2000, 150, 5};

    hybrid_tree_scheduler dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .q_wrt     (q_wrt),
        .q_read    (q_read),
        .q_data    (q_data),
        .q_full    (q_full),
        .q_empty   (q_empty),
        .q_top     (q_top),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic recompute();
        int m;
        m = 0;
        foreach (qm[i]) if (qm[i] > m) m = qm[i];
        q_top   = DW'(m);
        q_empty = (qm.size() == 0);
        q_full  = force_full || (qm.size() >= QCAP);
    endtask

    task automatic remove_max();
        int bi;
        bi = 0;
        foreach (qm[i]) if (qm[i] > qm[bi]) bi = i;
        qm.delete(bi);
    endtask

    // One clock: apply last cycle's strobe to the model just after the edge,
    // then sample strobes on the falling edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (pend) begin
            if (pend_r && qm.size() > 0) remove_max();
            if (pend_w) qm.push_back(int'(pend_d));
            pend = 1'b0;
            recompute();
        end
        @(negedge CLK);
        if (q_wrt === 1'b1 || q_read === 1'b1) begin
            pend   = 1'b1;
            pend_w = q_wrt;
            pend_r = q_read;
            pend_d = q_data;
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] op, input logic [DW-1:0] d);
        req_valid[i]        = v;
        req_op[2*i +: 2]    = op;
        req_data[DW*i +: DW] = d;
    endtask

    task automatic check_zero(input string p);
        check({p, "_ready"}, 32'(req_ready), 0);
        check({p, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({p, "_rsp_id"}, 32'(rsp_id), 0);
        check({p, "_rsp_data"}, 32'(rsp_data), 0);
        check({p, "_rsp_err"}, 32'(rsp_err), 0);
        check({p, "_q_wrt"}, 32'(q_wrt), 0);
        check({p, "_q_read"}, 32'(q_read), 0);
        check({p, "_q_data"}, 32'(q_data), 0);
        check({p, "_busy"}, 32'(busy), 0);
        check({p, "_rr_ptr"}, 32'(dut.rr_ptr), 0);
        check({p, "_state"}, 32'(dut.state), 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 60) begin
            tick();
            n++;
        end
        check("wait_idle", 32'(busy), 0);
    endtask

    initial begin
        RST       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_data  = '0;
        recompute();
        repeat (3) tick();
        check_zero("reset");
        RST = 1'b0;
        repeat (3) begin
            tick();
            check("idle_busy", 32'(busy), 0);
            check("idle_ready", 32'(req_ready), 0);
        end

        // Two simultaneous enqueues: requester 0 first, strobes 6 apart.
        set_req(0, 1'b1, 2'b00, 16'd100);
        set_req(1, 1'b1, 2'b00, 16'd500);
        #1;
        check("s1_grant0", 32'(req_ready), 32'b0001);
        tick();
        set_req(0, 1'b0, 2'b00, 16'd0);
        check("s1_wrt0", 32'(q_wrt), 1);
        check("s1_read0", 32'(q_read), 0);
        check("s1_qdata0", 32'(q_data), 100);
        check("s1_busy", 32'(busy), 1);
        tick();
        check("s1_rsp_valid0", 32'(rsp_valid), 1);
        check("s1_rsp_id0", 32'(rsp_id), 0);
        check("s1_rsp_err0", 32'(rsp_err), 0);
        check("s1_rsp_data0", 32'(rsp_data), 0);
        check("s1_wrt_off", 32'(q_wrt), 0);
        check("s1_ready_wait", 32'(req_ready), 0);
        for (int k = 3; k < 6; k++) begin
            tick();
            check("s1_gap_ready", 32'(req_ready), 0);
            check("s1_gap_wrt", 32'(q_wrt), 0);
        end
        tick();
        check("s1_grant1", 32'(req_ready), 32'b0010);
        tick();
        set_req(1, 1'b0, 2'b00, 16'd0);
        check("s1_wrt1", 32'(q_wrt), 1);
        check("s1_qdata1", 32'(q_data), 500);
        tick();
        check("s1_rsp_valid1", 32'(rsp_valid), 1);
        check("s1_rsp_id1", 32'(rsp_id), 1);
        check("s1_rsp_err1", 32'(rsp_err), 0);
        check("s1_rsp_data1", 32'(rsp_data), 0);
        wait_idle();
        check("s1_model_size", 32'(qm.size()), 2);

        // Dequeue from {900,300} by requester 2; 25 quiet cycles after strobe.
        qm.delete();
        qm.push_back(900);
        qm.push_back(300);
        recompute();
        set_req(2, 1'b1, 2'b01, 16'd0);
        #1;
        check("s2_grant2", 32'(req_ready), 32'b0100);
        tick();
        set_req(2, 1'b0, 2'b01, 16'd0);
        check("s2_read", 32'(q_read), 1);
        check("s2_wrt", 32'(q_wrt), 0);
        tick();
        check("s2_rsp_valid", 32'(rsp_valid), 1);
        check("s2_rsp_id", 32'(rsp_id), 2);
        check("s2_rsp_data", 32'(rsp_data), 900);
        check("s2_rsp_err", 32'(rsp_err), 0);
        check("s2_read_off", 32'(q_read), 0);
        set_req(3, 1'b1, 2'b00, 16'd42);
        grants  = 0;
        strobes = 0;
        for (int k = 3; k <= 25; k++) begin
            tick();
            if (req_ready != '0) grants++;
            if (q_read || q_wrt) strobes++;
        end
        check("s2_no_grant", 32'(grants), 0);
        check("s2_no_strobe", 32'(strobes), 0);
        tick();
        check("s2_grant3", 32'(req_ready), 32'b1000);
        tick();
        set_req(3, 1'b0, 2'b00, 16'd0);
        check("s2_enq_wrt", 32'(q_wrt), 1);
        check("s2_enq_data", 32'(q_data), 42);
        tick();
        check("s2_enq_rsp_id", 32'(rsp_id), 3);
        check("s2_enq_rsp_data", 32'(rsp_data), 0);
        wait_idle();

        // Replace on {700} by requester 3; requester 0 granted 6 cycles later.
        qm.delete();
        qm.push_back(700);
        recompute();
        set_req(3, 1'b1, 2'b10, 16'd50);
        #1;
        check("s3_grant3", 32'(req_ready), 32'b1000);
        tick();
        set_req(3, 1'b0, 2'b10, 16'd0);
        set_req(0, 1'b1, 2'b10, 16'd60);
        check("s3_wrt", 32'(q_wrt), 1);
        check("s3_read", 32'(q_read), 1);
        check("s3_qdata", 32'(q_data), 50);
        tick();
        check("s3_rsp_valid", 32'(rsp_valid), 1);
        check("s3_rsp_id", 32'(rsp_id), 3);
        check("s3_rsp_data", 32'(rsp_data), 700);
        for (int k = 3; k < 6; k++) begin
            tick();
            check("s3_gap_ready", 32'(req_ready), 0);
        end
        tick();
        check("s3_grant0", 32'(req_ready), 32'b0001);
        tick();
        set_req(0, 1'b0, 2'b10, 16'd0);
        check("s3_qdata0", 32'(q_data), 60);
        tick();
        check("s3_rsp_id0", 32'(rsp_id), 0);
        check("s3_rsp_data0", 32'(rsp_data), 50);
        wait_idle();

        // Dequeue while empty.
        qm.delete();
        recompute();
        set_req(1, 1'b1, 2'b01, 16'd0);
        #1;
        check("e1_grant", 32'(req_ready), 32'b0010);
        tick();
        set_req(1, 1'b0, 2'b01, 16'd0);
        check("e1_no_strobe", 32'({q_wrt, q_read}), 0);
        check("e1_rsp_early", 32'(rsp_valid), 0);
        check("e1_busy", 32'(busy), 1);
        tick();
        check("e1_rsp_valid", 32'(rsp_valid), 1);
        check("e1_rsp_err", 32'(rsp_err), 1);
        check("e1_rsp_id", 32'(rsp_id), 1);
        check("e1_rsp_data", 32'(rsp_data), 0);
        check("e1_no_strobe2", 32'({q_wrt, q_read}), 0);
        check("e1_idle", 32'(busy), 0);
        tick();
        check("e1_rsp_drop", 32'(rsp_valid), 0);
        check("e1_err_hold", 32'(rsp_err), 1);
        check("e1_id_hold", 32'(rsp_id), 1);

        // Enqueue while full.
        force_full = 1'b1;
        recompute();
        set_req(2, 1'b1, 2'b00, 16'd77);
        #1;
        check("e2_grant", 32'(req_ready), 32'b0100);
        tick();
        set_req(2, 1'b0, 2'b00, 16'd0);
        check("e2_no_strobe", 32'({q_wrt, q_read}), 0);
        tick();
        check("e2_rsp_valid", 32'(rsp_valid), 1);
        check("e2_rsp_err", 32'(rsp_err), 1);
        check("e2_rsp_id", 32'(rsp_id), 2);
        check("e2_no_strobe2", 32'({q_wrt, q_read}), 0);
        force_full = 1'b0;

        // Reserved opcode with a non-empty, non-full queue.
        qm.push_back(60);
        recompute();
        set_req(0, 1'b1, 2'b11, 16'd5);
        #1;
        check("e3_grant", 32'(req_ready), 32'b0001);
        tick();
        set_req(0, 1'b0, 2'b00, 16'd0);
        check("e3_no_strobe", 32'({q_wrt, q_read}), 0);
        tick();
        check("e3_rsp_valid", 32'(rsp_valid), 1);
        check("e3_rsp_err", 32'(rsp_err), 1);
        check("e3_rsp_id", 32'(rsp_id), 0);
        check("e3_rsp_data", 32'(rsp_data), 0);
        check("e3_no_strobe2", 32'({q_wrt, q_read}), 0);
        wait_idle();

        // Continuous replaces from all requesters, pointer starts at 1.
        qm.delete();
        qm.push_back(400);
        qm.push_back(300);
        recompute();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'b10, DW'(rdata[i]));
        #1;
        for (int n = 0; n < 8; n++) begin
            if (n > 0) begin
                g = 2;
                while (req_ready == '0 && g < 12) begin
                    tick();
                    g++;
                end
                check("rr_spacing", 32'(g), 6);
            end
            check("rr_grant", 32'(req_ready), 32'(1) << exp_id[n]);
            tick();
            check("rr_strobe", 32'({q_wrt, q_read}), 3);
            check("rr_qdata", 32'(q_data), 32'(rdata[exp_id[n]]));
            tick();
            check("rr_rsp_valid", 32'(rsp_valid), 1);
            check("rr_rsp_id", 32'(rsp_id), 32'(exp_id[n]));
            check("rr_rsp_data", 32'(rsp_data), 32'(exp_data[n]));
            check("rr_rsp_err", 32'(rsp_err), 0);
        end
        req_valid = '0;
        wait_idle();

        // Reset while waiting out a dequeue gap.
        set_req(1, 1'b1, 2'b01, 16'd0);
        #1;
        check("r1_grant", 32'(req_ready), 32'b0010);
        tick();
        set_req(1, 1'b0, 2'b01, 16'd0);
        tick();
        check("r1_rsp_data", 32'(rsp_data), 1000);
        tick();
        tick();
        check("r1_in_wait", 32'(busy), 1);
        RST = 1'b1;
        tick();
        check_zero("r1");
        RST = 1'b0;
        repeat (3) begin
            tick();
            check("r1_no_rsp", 32'(rsp_valid), 0);
            check("r1_busy", 32'(busy), 0);
        end

        // Reset during the strobe cycle drops the pending response.
        set_req(2, 1'b1, 2'b01, 16'd0);
        #1;
        check("r2_grant", 32'(req_ready), 32'b0100);
        tick();
        set_req(2, 1'b0, 2'b01, 16'd0);
        check("r2_read", 32'(q_read), 1);
        RST = 1'b1;
        tick();
        check("r2_no_rsp", 32'(rsp_valid), 0);
        check("r2_read_off", 32'(q_read), 0);
        check("r2_busy", 32'(busy), 0);
        RST = 1'b0;
        tick();
        check("r2_no_rsp_late", 32'(rsp_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
